// File: rtl/uart_receiver.sv
// UART receiver: start detect, mid-bit sampling, one-clk done / framing-error strobes.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int DATA_WIDTH = 4,
  parameter int TIME       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rx_done_tick,
  output logic                  frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int CW = $clog2(TIME);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(TIME / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(TIME - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  sync1, rxs, rxs_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit;
`endif

  // Idle-high reset keeps a released reset from looking like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Edge-triggered so a line held low never restarts a frame.
          if (rxs_d && !rxs) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_cnt == HALF_M1) begin
              if (!rxs) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              shreg    <= {rxs, shreg[DATA_WIDTH-1:1]};
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              par_bit  <= rxs;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (tick_cnt == LAST) begin
              state    <= IDLE;
              tick_cnt <= '0;
              if (rxs) begin
                dout         <= shreg;
                rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err   <= (^shreg) ^ par_bit;
`endif
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver: frames are described as expected events
// in a queue and matched against the strobes and dout every clock.
module tb_uart_receiver;
  localparam int DW = 4;
  localparam int TM = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_tick = 1'b0;
  logic          rx = 1'b1;
  logic [DW-1:0] dout;
  logic          rx_done_tick;
  logic          frame_err;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  uart_receiver #(.DATA_WIDTH(DW), .TIME(TM)) dut (
    .clk(clk),
    .reset(reset),
    .s_tick(s_tick),
    .rx(rx),
    .dout(dout),
    .rx_done_tick(rx_done_tick),
    .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  typedef struct {
    bit            err;
    logic [DW-1:0] data;
    bit            perr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_dout = '0;
  int            checks = 0;
  int            errors = 0;
  int            tick_div = 0;

  always #5 clk = ~clk;

  // One s_tick every 4 clocks.
  always @(negedge clk) begin
    tick_div = (tick_div + 1) % 4;
    s_tick = (tick_div == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("rst_dout", dout, 0);
      chk("rst_done", rx_done_tick, 0);
      chk("rst_ferr", frame_err, 0);
    end else begin
      if (rx_done_tick || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {rx_done_tick, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_done", rx_done_tick, !e.err);
          chk("strobe_ferr", frame_err, e.err);
          if (!e.err) model_dout = e.data;
`ifdef UART_RX_PARITY_EN
          chk("parity_err", parity_err, e.perr);
`endif
        end
      end else begin
`ifdef UART_RX_PARITY_EN
        chk("parity_idle", parity_err, 0);
`endif
      end
      chk("dout", dout, model_dout);
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff s_tick);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok, input bit pbit,
                            input int extra_low);
    exp_t e;
    e.err  = !stop_ok;
    e.data = d;
    e.perr = stop_ok && ((^d) ^ pbit);
    exp_q.push_back(e);
    rx = 1'b0;
    wait_ticks(TM);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      wait_ticks(TM);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    wait_ticks(TM);
`endif
    chk("pending_before_stop", exp_q.size(), 1);
    rx = stop_ok;
    wait_ticks(TM);
    chk("pending_after_stop", exp_q.size(), 0);
    if (!stop_ok) begin
      wait_ticks(extra_low * TM);
      rx = 1'b1;
      wait_ticks(4);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    bit            ok;
    bit            pb;
    reset = 1'b0;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("lit_reset_dout", dout, 0);

    send_frame(4'hA, 1'b1, 1'b0, 0);
    chk("lit_A", dout, 4'hA);

    // Short low pulse: start rejected at mid-bit.
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(3 * TM);
    chk("lit_glitch_dout", dout, 4'hA);

    send_frame(4'h5, 1'b1, 1'b0, 0);
    chk("lit_5", dout, 4'h5);

    send_frame(4'h3, 1'b0, 1'b0, 2);
    wait_ticks(TM);
    chk("lit_after_ferr", dout, 4'h5);

    send_frame(4'hC, 1'b1, 1'b0, 0);
    chk("lit_C", dout, 4'hC);

    send_frame(4'hF, 1'b1, 1'b0, 0);
    chk("lit_F", dout, 4'hF);
    send_frame(4'h0, 1'b1, 1'b0, 0);
    chk("lit_0", dout, 4'h0);
    wait_ticks(TM);

    // Reset during data bit 2.
    rx = 1'b0;
    wait_ticks(TM);
    rx = 1'b1;
    wait_ticks(TM);
    rx = 1'b0;
    wait_ticks(TM);
    rx = 1'b1;
    wait_ticks(TM / 2);
    exp_q.delete();
    model_dout = '0;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    wait_ticks(2 * TM);
    chk("lit_after_reset", dout, 0);

    send_frame(4'h6, 1'b1, 1'b0, 0);
    chk("lit_6", dout, 4'h6);

`ifdef UART_RX_PARITY_EN
    send_frame(4'h7, 1'b1, 1'b1, 0);
    send_frame(4'h7, 1'b1, 1'b0, 0);
    chk("lit_7", dout, 4'h7);
    wait_ticks(TM);
`endif

    for (int n = 0; n < 24; n++) begin
      d  = DW'($urandom_range(0, 15));
      ok = ($urandom_range(0, 4) != 0);
      pb = 1'($urandom_range(0, 1));
      send_frame(d, ok, pb, int'($urandom_range(0, 2)));
      wait_ticks(int'($urandom_range(0, 12)));
    end
    wait_ticks(2 * TM);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
